// File: rtl/fifo_rd_pkg.sv
// rtl/fifo_rd_pkg.sv - shared types and constants for the FIFO read-side drain stage
package fifo_rd_pkg;

  localparam int SKID_DEPTH = 3;

  typedef logic [1:0] ptr_t;
  typedef logic [1:0] occ_t;

  localparam occ_t OCC_FULL = occ_t'(SKID_DEPTH);

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(SKID_DEPTH - 1)) ? ptr_t'(0) : ptr_t'(p + 2'd1);
  endfunction

endpackage

// File: rtl/rd_skid_buf.sv
// rtl/rd_skid_buf.sv - 3-entry circular skid buffer absorbing the FIFO read latency
module rd_skid_buf
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] head_o,
  output occ_t                  occ_o
);

  logic [DATA_WIDTH-1:0] mem_q [SKID_DEPTH];
  ptr_t head_q, head_d;
  ptr_t tail_q, tail_d;
  occ_t occ_q, occ_d;
  logic do_push, do_pop;

  // A push into a full buffer is only accepted when a pop frees a slot in the same cycle.
  always_comb begin
    do_pop  = pop_i && (occ_q != '0);
    do_push = push_i && ((occ_q != OCC_FULL) || do_pop);
    head_d  = do_pop  ? ptr_inc(head_q) : head_q;
    tail_d  = do_push ? ptr_inc(tail_q) : tail_q;
    occ_d   = occ_q;
    if (do_push && !do_pop) begin
      occ_d = occ_q + 2'd1;
    end else if (!do_push && do_pop) begin
      occ_d = occ_q - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[tail_q] <= push_data_i;
    end
  end

  assign head_o = mem_q[head_q];
  assign occ_o  = occ_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// rtl/fifo_rd_stream.sv - drains the synchronous FIFO into a packet-framed valid/ready stream
module fifo_rd_stream
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int PKT_LEN    = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic                  fifo_underflow,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic [CNT_WIDTH-1:0]  words_sent,
  output logic                  err_underflow
);

  localparam int BEAT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(PKT_LEN - 1);

  occ_t                  occ;
  logic [2:0]            level;
  logic                  push, pop;
  logic                  inflight_q, inflight_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic [CNT_WIDTH-1:0]  words_q, words_d;
  logic                  err_q, err_d;

  // Reserve a slot for the read already in flight so a returning word always fits.
  assign level      = {1'b0, occ} + {2'b00, inflight_q};
  assign fifo_rd_en = !rst && !fifo_empty && (level < 3'(SKID_DEPTH));

  assign push    = inflight_q && !fifo_underflow;
  assign m_valid = (occ != '0);
  assign pop     = m_valid && m_ready;
  assign m_last  = m_valid && (beat_q == BEAT_LAST);

  rd_skid_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk        (clk),
    .rst        (rst),
    .push_i     (push),
    .push_data_i(fifo_data_out),
    .pop_i      (pop),
    .head_o     (m_data),
    .occ_o      (occ)
  );

  always_comb begin
    inflight_d = fifo_rd_en;
    beat_d     = beat_q;
    words_d    = words_q;
    err_d      = err_q;
    if (pop) begin
      beat_d  = (beat_q == BEAT_LAST) ? '0 : beat_q + 1'b1;
      words_d = words_q + 1'b1;
    end
    if (inflight_q && fifo_underflow) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q <= 1'b0;
      beat_q     <= '0;
      words_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      beat_q     <= beat_d;
      words_q    <= words_d;
      err_q      <= err_d;
    end
  end

  assign words_sent    = words_q;
  assign err_underflow = err_q;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb/tb_fifo_rd_stream.sv - directed self-checking bench for fifo_rd_stream
module tb_fifo_rd_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic        fifo_empty, fifo_underflow, fifo_rd_en;
  logic [15:0] fifo_data_out = 16'hDEAD;
  logic        m_valid, m_ready, m_last, err_underflow;
  logic [15:0] m_data;
  logic [15:0] words_sent;

  logic        fifo_rd_en2, m_valid2, m_ready2, m_last2, err_underflow2;
  logic [15:0] m_data2, fifo_data_out2;
  logic [3:0]  words_sent2;

  always #5 clk = ~clk;

  fifo_rd_stream #(.DATA_WIDTH(16), .PKT_LEN(8), .CNT_WIDTH(16)) u_dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_underflow(fifo_underflow),
    .fifo_data_out(fifo_data_out), .fifo_rd_en(fifo_rd_en), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .words_sent(words_sent),
    .err_underflow(err_underflow)
  );

  fifo_rd_stream #(.DATA_WIDTH(16), .PKT_LEN(1), .CNT_WIDTH(4)) u_wrap (
    .clk(clk), .rst(rst), .fifo_empty(1'b0), .fifo_underflow(1'b0),
    .fifo_data_out(fifo_data_out2), .fifo_rd_en(fifo_rd_en2), .m_valid(m_valid2),
    .m_ready(m_ready2), .m_data(m_data2), .m_last(m_last2), .words_sent(words_sent2),
    .err_underflow(err_underflow2)
  );

  // FIFO model: one-cycle read latency, registered underflow flag
  logic [15:0] fmem [0:255];
  int          wp = 0;
  int          rp = 0;
  int          cyc = 0;
  logic        uf_q = 1'b0;
  logic        force_uf = 1'b0;

  assign fifo_empty     = (wp == rp);
  assign fifo_underflow = uf_q | force_uf;
  assign fifo_data_out2 = cyc[15:0];

  always @(posedge clk) begin
    cyc  <= cyc + 1;
    uf_q <= fifo_rd_en && fifo_empty;
    if (fifo_rd_en) begin
      fifo_data_out <= fmem[rp[7:0]];
      rp            <= rp + 1;
    end else begin
      fifo_data_out <= 16'hDEAD;
    end
  end

  logic [15:0] got_data [0:511];
  logic        got_last [0:511];
  int          got_cyc  [0:511];
  int          rd_cyc   [0:511];
  int          n_got = 0, n_rd = 0, rd_on_empty = 0, cap_full = 0, hs2 = 0, last2_bad = 0;

  always @(negedge clk) begin
    if (m_valid && m_ready) begin
      got_data[n_got] <= m_data;
      got_last[n_got] <= m_last;
      got_cyc[n_got]  <= cyc;
      n_got           <= n_got + 1;
    end
    if (fifo_rd_en) begin
      rd_cyc[n_rd] <= cyc;
      n_rd         <= n_rd + 1;
    end
    if (fifo_rd_en && fifo_empty) rd_on_empty <= rd_on_empty + 1;
    if (u_dut.inflight_q && !fifo_underflow && (u_dut.occ == 2'd3)) cap_full <= cap_full + 1;
    if (m_valid2 && m_ready2) hs2 <= hs2 + 1;
    if (m_last2 != m_valid2) last2_bad <= last2_bad + 1;
  end

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [15:0] v);
    fmem[wp[7:0]] = v;
    wp = wp + 1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m_ready = 1'b0;
    repeat (2) step();
    rst = 1'b0;
  endtask

  int g_base, r_base, h_base, guard;
  logic [15:0] exp_next;

  initial begin
    rst = 1'b1;
    m_ready = 1'b0;
    m_ready2 = 1'b0;

    // reset values with a non-empty FIFO, then fill-and-drain
    for (int i = 1; i <= 16; i++) load(16'(i));
    repeat (2) step();
    check("rst_rd_en", fifo_rd_en, 0);
    check("rst_valid", m_valid, 0);
    check("rst_last", m_last, 0);
    check("rst_err", err_underflow, 0);
    check("rst_words", words_sent, 0);
    g_base = n_got;
    r_base = n_rd;
    rst = 1'b0;
    m_ready = 1'b1;
    repeat (30) step();
    check("fill_count", n_got - g_base, 16);
    check("fill_reads", n_rd - r_base, 16);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("fill_data%0d", i), got_data[g_base + i], i + 1);
      check($sformatf("fill_last%0d", i), got_last[g_base + i], (i % 8) == 7);
    end
    check("fill_latency", got_cyc[g_base] - rd_cyc[r_base], 2);
    check("fill_thruput", got_cyc[g_base + 15] - got_cyc[g_base], 15);
    check("fill_words", words_sent, 16);
    check("fill_idle", m_valid, 0);

    // backpressure
    do_reset();
    g_base = n_got;
    r_base = n_rd;
    for (int i = 0; i < 10; i++) load(16'h0100 + 16'(i));
    repeat (8) step();
    check("bp_reads", n_rd - r_base, 3);
    check("bp_rd_en", fifo_rd_en, 0);
    check("bp_valid", m_valid, 1);
    check("bp_data", m_data, 16'h0100);
    repeat (3) step();
    check("bp_hold", m_data, 16'h0100);
    check("bp_none", n_got - g_base, 0);
    m_ready = 1'b1;
    repeat (20) step();
    check("bp_count", n_got - g_base, 10);
    for (int i = 0; i < 10; i++)
      check($sformatf("bp_data%0d", i), got_data[g_base + i], 16'h0100 + i);
    check("bp_words", words_sent, 10);

    // single-word FIFO
    do_reset();
    m_ready = 1'b1;
    g_base = n_got;
    r_base = n_rd;
    load(16'h00AA);
    repeat (10) step();
    check("one_reads", n_rd - r_base, 1);
    check("one_count", n_got - g_base, 1);
    check("one_data", got_data[g_base], 16'h00AA);
    check("one_err", err_underflow, 0);

    // forced underflow on the second read
    do_reset();
    m_ready = 1'b1;
    g_base = n_got;
    r_base = n_rd;
    load(16'h0031);
    load(16'h0032);
    load(16'h0033);
    step();
    step();
    force_uf = 1'b1;
    check("uf_before", err_underflow, 0);
    step();
    force_uf = 1'b0;
    check("uf_after", err_underflow, 1);
    repeat (10) step();
    check("uf_reads", n_rd - r_base, 3);
    check("uf_count", n_got - g_base, 2);
    check("uf_data0", got_data[g_base], 16'h0031);
    check("uf_data1", got_data[g_base + 1], 16'h0033);
    check("uf_sticky", err_underflow, 1);
    check("uf_words", words_sent, 2);

    // reset in the middle of a packet with a read in flight
    do_reset();
    m_ready = 1'b1;
    g_base = n_got;
    for (int i = 0; i < 20; i++) load(16'h0200 + 16'(i));
    guard = 0;
    while ((n_got - g_base) < 5 && guard < 50) begin
      step();
      guard++;
    end
    check("mid_wait", n_got - g_base, 5);
    check("mid_inflight", fifo_rd_en, 1);
    rst = 1'b1;
    m_ready = 1'b0;
    step();
    check("mid_rd_en", fifo_rd_en, 0);
    check("mid_valid", m_valid, 0);
    check("mid_last", m_last, 0);
    check("mid_words", words_sent, 0);
    check("mid_err", err_underflow, 0);
    step();
    rst = 1'b0;
    exp_next = fmem[rp[7:0]];
    m_ready = 1'b1;
    g_base = n_got;
    repeat (15) step();
    check("mid_count", n_got - g_base >= 8, 1);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("mid_data%0d", i), got_data[g_base + i], exp_next + 16'(i));
      check($sformatf("mid_last%0d", i), got_last[g_base + i], i == 7);
    end

    // 4-bit counter wrap, one-word packets
    step();
    h_base = hs2;
    m_ready2 = 1'b1;
    guard = 0;
    while ((hs2 - h_base) < 17 && guard < 100) begin
      step();
      guard++;
    end
    m_ready2 = 1'b0;
    step();
    check("wrap_hs", hs2 - h_base, 17);
    check("wrap_words", words_sent2, 1);
    check("wrap_last", last2_bad, 0);

    check("never_rd_empty", rd_on_empty, 0);
    check("never_cap_full", cap_full, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
